// File: rtl/csa_pipe_adder_pkg.sv
// Shared helpers for the segmented carry-propagate adder: segment count,
// per-segment width and the default segment width.
package csa_pipe_pkg;

    localparam int SEG_W_DEFAULT = 8;

    // Number of carry-propagate segments (ceiling division).
    function automatic int seg_num(input int data_w, input int seg_w);
        return (data_w + seg_w - 1) / seg_w;
    endfunction

    // Width of segment k; the top segment may be narrower than seg_w.
    function automatic int seg_width(input int k, input int data_w, input int seg_w);
        int rem;
        rem = data_w - k * seg_w;
        return (rem < seg_w) ? rem : seg_w;
    endfunction

endpackage

// File: rtl/csa_pipe_adder_if.sv
// Handshake/data bundle between the wallace compressor, the adder and its
// consumer. The sideband tag exists only when CSA_PIPE_TAG_EN is defined.
interface csa_pipe_adder_if #(
    parameter int DATA_W = 16,
    parameter int TAG_W  = 4
);
    logic              i_vld;
    logic              o_rdy;
    logic [DATA_W-1:0] i_sum;
    logic [DATA_W-1:0] i_carry;
    logic              o_vld;
    logic              i_rdy;
    logic [DATA_W-1:0] o_res;
    logic              o_cout;
`ifdef CSA_PIPE_TAG_EN
    logic [TAG_W-1:0]  i_tag;
    logic [TAG_W-1:0]  o_tag;
`endif

    // Adder side.
    modport slave (
        input  i_vld, i_sum, i_carry, i_rdy,
`ifdef CSA_PIPE_TAG_EN
        input  i_tag,
        output o_tag,
`endif
        output o_rdy, o_vld, o_res, o_cout
    );

    // Producer/consumer side.
    modport master (
        output i_vld, i_sum, i_carry, i_rdy,
`ifdef CSA_PIPE_TAG_EN
        output i_tag,
        input  o_tag,
`endif
        input  o_rdy, o_vld, o_res, o_cout
    );

endinterface

// File: rtl/csa_pipe_adder_stage.sv
// One carry-propagate segment: adds segment K of the travelling sum/carry
// words plus the carry from the previous stage, and holds the transaction
// while downstream is stalled. Optional tag under CSA_PIPE_TAG_EN.
module csa_pipe_stage
    import csa_pipe_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int SEG_W  = SEG_W_DEFAULT,
    parameter int TAG_W  = 4,
    parameter int K      = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prev_vld,
    input  logic [DATA_W-1:0] prev_res,
    input  logic [DATA_W-1:0] prev_car,
    input  logic              prev_cout,
`ifdef CSA_PIPE_TAG_EN
    input  logic [TAG_W-1:0]  prev_tag,
    output logic [TAG_W-1:0]  tag,
`endif
    input  logic              next_adv,
    output logic              adv,
    output logic              vld,
    output logic [DATA_W-1:0] res,
    output logic [DATA_W-1:0] car,
    output logic              cout
);
    localparam int LO = K * SEG_W;
    localparam int W  = seg_width(K, DATA_W, SEG_W);

    logic [W:0]        seg_sum;
    logic [DATA_W-1:0] res_nxt;
    logic [DATA_W-1:0] car_nxt;

    assign seg_sum = {1'b0, prev_res[LO +: W]} + {1'b0, prev_car[LO +: W]}
                   + {{W{1'b0}}, prev_cout};

    // Stage may load when empty or when the stage after it is moving.
    assign adv = !vld || next_adv;

    // Splice the resolved segment in; resolved carry bits are cleared.
    always_comb begin
        res_nxt           = prev_res;
        res_nxt[LO +: W]  = seg_sum[W-1:0];
        car_nxt           = prev_car;
        car_nxt[LO +: W]  = '0;
    end

    // Stage registers: valid follows the advance rule, data only for valid beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld  <= 1'b0;
            res  <= '0;
            car  <= '0;
            cout <= 1'b0;
`ifdef CSA_PIPE_TAG_EN
            tag  <= '0;
`endif
        end else if (adv) begin
            vld <= prev_vld;
            if (prev_vld) begin
                res  <= res_nxt;
                car  <= car_nxt;
                cout <= seg_sum[W];
`ifdef CSA_PIPE_TAG_EN
                tag  <= prev_tag;
`endif
            end
        end
    end

endmodule

// File: rtl/csa_pipe_adder.sv
// Pipelined carry-propagate adder resolving the wallace sum/carry pair.
// The carry chain is cut into SEG_W-bit segments, one register stage each.
// Optional sideband tag enabled by defining CSA_PIPE_TAG_EN.
module csa_pipe_adder
    import csa_pipe_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int SEG_W  = SEG_W_DEFAULT,
    parameter int TAG_W  = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    csa_pipe_adder_if.slave    bus
);
    localparam int NSEG = seg_num(DATA_W, SEG_W);

    // Index 0 is the upstream input; index k+1 is the output of stage k.
    logic              vld_s  [NSEG+1];
    logic [DATA_W-1:0] res_s  [NSEG+1];
    logic [DATA_W-1:0] car_s  [NSEG+1];
    logic              cout_s [NSEG+1];
`ifdef CSA_PIPE_TAG_EN
    logic [TAG_W-1:0]  tag_s  [NSEG+1];
    assign tag_s[0] = bus.i_tag;
    assign bus.o_tag = tag_s[NSEG];
`endif

    assign vld_s[0]  = bus.i_vld;
    assign res_s[0]  = bus.i_sum;
    assign car_s[0]  = bus.i_carry;
    assign cout_s[0] = 1'b0;

    // Every carry bit is resolved by the last stage; nothing consumes it.
    logic unused_car;
    assign unused_car = ^car_s[NSEG];

    for (genvar k = 0; k < NSEG; k++) begin : g_seg
        logic adv;
        logic next_adv;

        if (k == NSEG - 1) begin : g_tail
            assign next_adv = bus.i_rdy;
        end else begin : g_body
            assign next_adv = g_seg[k+1].adv;
        end

        csa_pipe_stage #(
            .DATA_W (DATA_W),
            .SEG_W  (SEG_W),
            .TAG_W  (TAG_W),
            .K      (k)
        ) u_stage (
            .clk       (i_clk),
            .rst       (i_rst),
            .prev_vld  (vld_s[k]),
            .prev_res  (res_s[k]),
            .prev_car  (car_s[k]),
            .prev_cout (cout_s[k]),
`ifdef CSA_PIPE_TAG_EN
            .prev_tag  (tag_s[k]),
            .tag       (tag_s[k+1]),
`endif
            .next_adv  (next_adv),
            .adv       (adv),
            .vld       (vld_s[k+1]),
            .res       (res_s[k+1]),
            .car       (car_s[k+1]),
            .cout      (cout_s[k+1])
        );
    end

    assign bus.o_rdy  = g_seg[0].adv;
    assign bus.o_vld  = vld_s[NSEG];
    assign bus.o_res  = res_s[NSEG];
    assign bus.o_cout = cout_s[NSEG];

endmodule

// File: tb/tb_csa_pipe_adder.sv
// Directed bench for csa_pipe_adder: a 16-bit/8-bit-segment instance and a
// 20-bit/8-bit-segment instance (3 stages, 4-bit top segment). Tag checks
// are compiled in when CSA_PIPE_TAG_EN is defined.
module tb_csa_pipe_adder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    csa_pipe_adder_if #(.DATA_W(16), .TAG_W(4)) bus_a ();
    csa_pipe_adder_if #(.DATA_W(20), .TAG_W(4)) bus_b ();

    csa_pipe_adder #(.DATA_W(16), .SEG_W(8), .TAG_W(4)) dut_a (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus_a)
    );

    csa_pipe_adder #(.DATA_W(20), .SEG_W(8), .TAG_W(4)) dut_b (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus_b)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int tx, rx, extra;
    logic fire;

    logic [15:0] s_sum  [6] = '{16'h0F0F, 16'h7FFF, 16'h00AA, 16'h8001, 16'h1111, 16'hFF00};
    logic [15:0] s_car  [6] = '{16'h00F1, 16'h0001, 16'h0055, 16'h8001, 16'h2222, 16'h0100};
    logic [15:0] s_res  [6] = '{16'h1000, 16'h8000, 16'h00FF, 16'h0002, 16'h3333, 16'h0000};
    logic        s_cout [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // One isolated transaction on the 2-stage instance.
    task automatic send_a(input logic [15:0] s, input logic [15:0] c,
                          input logic [15:0] er, input logic ec, input string name);
        @(posedge clk); #1;
        bus_a.i_vld = 1'b1; bus_a.i_sum = s; bus_a.i_carry = c;
        @(posedge clk); #1;
        bus_a.i_vld = 1'b0;
        @(negedge clk);
        chk({name, "_lat1"}, 32'(bus_a.o_vld), 32'h0);
        @(posedge clk); @(negedge clk);
        chk({name, "_vld"},  32'(bus_a.o_vld),  32'h1);
        chk({name, "_res"},  32'(bus_a.o_res),  32'(er));
        chk({name, "_cout"}, 32'(bus_a.o_cout), 32'(ec));
    endtask

    // One isolated transaction on the 3-stage instance.
    task automatic send_b(input logic [19:0] s, input logic [19:0] c, input logic [3:0] t,
                          input logic [19:0] er, input logic ec, input string name);
        @(posedge clk); #1;
        bus_b.i_vld = 1'b1; bus_b.i_sum = s; bus_b.i_carry = c;
`ifdef CSA_PIPE_TAG_EN
        bus_b.i_tag = t;
`endif
        @(posedge clk); #1;
        bus_b.i_vld = 1'b0;
        @(negedge clk);
        chk({name, "_lat1"}, 32'(bus_b.o_vld), 32'h0);
        @(posedge clk); @(negedge clk);
        chk({name, "_lat2"}, 32'(bus_b.o_vld), 32'h0);
        @(posedge clk); @(negedge clk);
        chk({name, "_vld"},  32'(bus_b.o_vld),  32'h1);
        chk({name, "_res"},  32'(bus_b.o_res),  32'(er));
        chk({name, "_cout"}, 32'(bus_b.o_cout), 32'(ec));
`ifdef CSA_PIPE_TAG_EN
        chk({name, "_tag"},  32'(bus_b.o_tag),  32'(t));
`endif
    endtask

    initial begin
        rst = 1'b1;
        bus_a.i_vld = 1'b0; bus_a.i_rdy = 1'b1; bus_a.i_sum = '0; bus_a.i_carry = '0;
        bus_b.i_vld = 1'b0; bus_b.i_rdy = 1'b1; bus_b.i_sum = '0; bus_b.i_carry = '0;
`ifdef CSA_PIPE_TAG_EN
        bus_a.i_tag = '0; bus_b.i_tag = '0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_a_vld",  32'(bus_a.o_vld),  32'h0);
        chk("rst_a_res",  32'(bus_a.o_res),  32'h0);
        chk("rst_a_cout", 32'(bus_a.o_cout), 32'h0);
        chk("rst_a_rdy",  32'(bus_a.o_rdy),  32'h1);
        chk("rst_b_vld",  32'(bus_b.o_vld),  32'h0);
        chk("rst_b_rdy",  32'(bus_b.o_rdy),  32'h1);
`ifdef CSA_PIPE_TAG_EN
        chk("rst_b_tag",  32'(bus_b.o_tag),  32'h0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;

        // Single transactions, 2 stages.
        send_a(16'h00FF, 16'h0001, 16'h0100, 1'b0, "a_ff_1");
        send_a(16'hFFFF, 16'h0001, 16'h0000, 1'b1, "a_wrap");
        send_a(16'h1234, 16'h4321, 16'h5555, 1'b0, "a_5555");
        send_a(16'h00FF, 16'hFF01, 16'h0000, 1'b1, "a_segcarry");

        // Back-to-back stream with i_rdy=1: one result per cycle.
        repeat (2) @(posedge clk);
        #1;
        bus_a.i_vld = 1'b1; bus_a.i_sum = 16'h0001; bus_a.i_carry = 16'h0001;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            if (c < 4) begin
                bus_a.i_sum = 16'(c + 1); bus_a.i_carry = 16'(c + 1);
            end else begin
                bus_a.i_vld = 1'b0;
            end
            @(negedge clk);
            chk($sformatf("b2b_rdy%0d", c), 32'(bus_a.o_rdy), 32'h1);
            if (c == 1) begin
                chk("b2b_vld1", 32'(bus_a.o_vld), 32'h0);
            end else begin
                chk($sformatf("b2b_vld%0d", c), 32'(bus_a.o_vld), 32'h1);
                chk($sformatf("b2b_res%0d", c), 32'(bus_a.o_res), 32'(2 * (c - 1)));
            end
        end

        // Stall with continuous i_vld and i_rdy=0: exactly 2 accepted.
        repeat (3) @(posedge clk);
        #1;
        bus_a.i_rdy = 1'b0;
        tx = 0;
        bus_a.i_vld = 1'b1; bus_a.i_sum = s_sum[0]; bus_a.i_carry = s_car[0];
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            fire = bus_a.o_rdy & bus_a.i_vld;
            if (c >= 2) begin
                chk($sformatf("stall_rdy%0d", c), 32'(bus_a.o_rdy), 32'h0);
                chk($sformatf("stall_vld%0d", c), 32'(bus_a.o_vld), 32'h1);
                chk($sformatf("stall_res%0d", c), 32'(bus_a.o_res), 32'(s_res[0]));
            end
            @(posedge clk); #1;
            if (fire) tx++;
            if (tx < 6) begin
                bus_a.i_sum = s_sum[tx]; bus_a.i_carry = s_car[tx];
            end else begin
                bus_a.i_vld = 1'b0;
            end
        end
        chk("stall_accepted", 32'(tx), 32'h2);

        // Release: remaining results in order, none lost or duplicated.
        bus_a.i_rdy = 1'b1;
        rx = 0;
        for (int c = 0; c < 40 && rx < 6; c++) begin
            @(negedge clk);
            if (bus_a.o_vld && rx < 6) begin
                chk($sformatf("drain_res%0d", rx),  32'(bus_a.o_res),  32'(s_res[rx]));
                chk($sformatf("drain_cout%0d", rx), 32'(bus_a.o_cout), 32'(s_cout[rx]));
                rx++;
            end
            fire = bus_a.o_rdy & bus_a.i_vld;
            @(posedge clk); #1;
            if (fire) tx++;
            if (tx < 6) begin
                bus_a.i_sum = s_sum[tx]; bus_a.i_carry = s_car[tx];
            end else begin
                bus_a.i_vld = 1'b0;
            end
        end
        chk("drain_count", 32'(rx), 32'h6);
        chk("drain_sent",  32'(tx), 32'h6);
        extra = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus_a.o_vld) extra++;
        end
        chk("drain_extra", 32'(extra), 32'h0);

        // Reset with a full, stalled pipe.
        @(posedge clk); #1;
        bus_a.i_rdy = 1'b0;
        bus_a.i_vld = 1'b1; bus_a.i_sum = 16'h1234; bus_a.i_carry = 16'h1111;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        bus_a.i_vld = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_vld",  32'(bus_a.o_vld),  32'h0);
        chk("midrst_res",  32'(bus_a.o_res),  32'h0);
        chk("midrst_cout", 32'(bus_a.o_cout), 32'h0);
        chk("midrst_rdy",  32'(bus_a.o_rdy),  32'h1);
        bus_a.i_rdy = 1'b1;
        extra = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus_a.o_vld) extra++;
        end
        chk("midrst_stale", 32'(extra), 32'h0);

        // 20-bit, 3 stages, 4-bit top segment.
        send_b(20'hFFFFF, 20'h00001, 4'h3, 20'h00000, 1'b1, "b_wrap");
        send_b(20'h12345, 20'h0EDCB, 4'hA, 20'h21110, 1'b0, "b_mix");
        send_b(20'h0FFFF, 20'h00001, 4'h5, 20'h10000, 1'b0, "b_top_seg");
        send_b(20'h80000, 20'h80000, 4'hF, 20'h00000, 1'b1, "b_top_cout");

        // Two back-to-back tagged beats keep their own results.
        repeat (2) @(posedge clk);
        #1;
        bus_b.i_vld = 1'b1; bus_b.i_sum = 20'hFFFFF; bus_b.i_carry = 20'h00001;
`ifdef CSA_PIPE_TAG_EN
        bus_b.i_tag = 4'h3;
`endif
        @(posedge clk); #1;
        bus_b.i_sum = 20'h12345; bus_b.i_carry = 20'h0EDCB;
`ifdef CSA_PIPE_TAG_EN
        bus_b.i_tag = 4'hA;
`endif
        @(posedge clk); #1;
        bus_b.i_vld = 1'b0;
        @(negedge clk);
        chk("bb_vld_e2", 32'(bus_b.o_vld), 32'h0);
        @(posedge clk); @(negedge clk);
        chk("bb_vld_e3", 32'(bus_b.o_vld),  32'h1);
        chk("bb_res0",   32'(bus_b.o_res),  32'h00000);
        chk("bb_cout0",  32'(bus_b.o_cout), 32'h1);
`ifdef CSA_PIPE_TAG_EN
        chk("bb_tag0",   32'(bus_b.o_tag),  32'h3);
`endif
        @(posedge clk); @(negedge clk);
        chk("bb_vld_e4", 32'(bus_b.o_vld),  32'h1);
        chk("bb_res1",   32'(bus_b.o_res),  32'h21110);
        chk("bb_cout1",  32'(bus_b.o_cout), 32'h0);
`ifdef CSA_PIPE_TAG_EN
        chk("bb_tag1",   32'(bus_b.o_tag),  32'hA);
`endif
        @(posedge clk); @(negedge clk);
        chk("bb_vld_e5", 32'(bus_b.o_vld), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
